// File: rtl/divider_unsigned_iter.sv
// divider_unsigned_iter: multi-cycle restoring unsigned divider with valid/ready handshakes,
// retiring STEPS_PER_CYCLE quotient bits per clock.
module divider_unsigned_iter #(
    parameter int WIDTH           = 32,
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_by_zero
);
    localparam int N  = WIDTH / STEPS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);

    generate
        if ((STEPS_PER_CYCLE != 1 && STEPS_PER_CYCLE != 2 && STEPS_PER_CYCLE != 4 &&
             STEPS_PER_CYCLE != 8) || (WIDTH % STEPS_PER_CYCLE) != 0) begin : g_bad_param
            $error("divider_unsigned_iter: illegal STEPS_PER_CYCLE/WIDTH combination");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_dvd, r_dvs, r_rem, r_quot, r_o_quot, r_o_rem;
    logic            r_dbz, r_o_dbz, r_i_ready, r_o_valid;
    logic [WIDTH-1:0] w_dvd, w_rem, w_quot;
    logic [WIDTH:0]  w_t;

    assign i_ready       = r_i_ready;
    assign o_valid       = r_o_valid;
    assign o_quotient    = r_o_quot;
    assign o_remainder   = r_o_rem;
    assign o_div_by_zero = r_o_dbz;

    // Chained restoring steps; the shifted remainder is WIDTH+1 bits so the carry-out is kept.
    always_comb begin
        w_dvd  = r_dvd;
        w_rem  = r_rem;
        w_quot = r_quot;
        w_t    = '0;
        for (int s = 0; s < STEPS_PER_CYCLE; s++) begin
            w_t    = {w_rem, w_dvd[WIDTH-1]};
            w_rem  = (w_t >= {1'b0, r_dvs}) ? w_t[WIDTH-1:0] - r_dvs : w_t[WIDTH-1:0];
            w_quot = {w_quot[WIDTH-2:0], w_t >= {1'b0, r_dvs}};
            w_dvd  = w_dvd << 1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_dvd     <= '0;
            r_dvs     <= '0;
            r_rem     <= '0;
            r_quot    <= '0;
            r_dbz     <= 1'b0;
            r_o_quot  <= '0;
            r_o_rem   <= '0;
            r_o_dbz   <= 1'b0;
            r_i_ready <= 1'b0;
            r_o_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_i_ready <= 1'b1;
                    if (i_valid && r_i_ready) begin
                        r_state   <= S_BUSY;
                        r_i_ready <= 1'b0;
                        r_dvd     <= i_dividend;
                        r_dvs     <= i_divisor;
                        r_dbz     <= (i_divisor == '0);
                        r_rem     <= '0;
                        r_quot    <= '0;
                        r_cnt     <= CW'(N);
                    end
                end
                S_BUSY: begin
                    r_dvd  <= w_dvd;
                    r_rem  <= w_rem;
                    r_quot <= w_quot;
                    r_cnt  <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state   <= S_DONE;
                        r_o_valid <= 1'b1;
                        r_o_quot  <= w_quot;
                        r_o_rem   <= w_rem;
                        r_o_dbz   <= r_dbz;
                    end
                end
                S_DONE: begin
                    if (o_ready) begin
                        r_state   <= S_IDLE;
                        r_o_valid <= 1'b0;
                        r_i_ready <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_divider_unsigned_iter.sv
// tb_divider_unsigned_iter: directed and random checks on four dividers (1, 2, 4, 8 steps per cycle).
module tb_divider_unsigned_iter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  iv, ordy;
    wire  [3:0]  ir, ov, dz;
    logic [31:0] dvd [4];
    logic [31:0] dvs [4];
    wire  [31:0] q [4];
    wire  [31:0] r [4];
    int          checks = 0, errors = 0;
    string       cur = "";

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_dut
            divider_unsigned_iter #(.WIDTH(32), .STEPS_PER_CYCLE(1 << g)) u_dut (
                .clk(clk), .rst_n(rst_n), .i_valid(iv[g]), .i_ready(ir[g]),
                .i_dividend(dvd[g]), .i_divisor(dvs[g]), .o_valid(ov[g]), .o_ready(ordy[g]),
                .o_quotient(q[g]), .o_remainder(r[g]), .o_div_by_zero(dz[g]));
        end
    endgenerate

    typedef struct {
        logic [31:0] a, b, eq, er;
        logic        ez;
    } vec_t;
    vec_t vt [8];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s [%s] got=%0h expected=%0h", nm, cur, got, exp);
        end
    endtask

    task automatic run_op(input int d, input logic [31:0] a, input logic [31:0] b, input int bp,
                          input bit spam, input logic [31:0] eq, input logic [31:0] er,
                          input logic ez);
        int n = 0;
        int lat = 0;
        while (!ir[d] && n < 100) begin @(posedge clk); #1; n++; end
        chk("accept_ready", ir[d], 1);
        iv[d] = 1'b1; dvd[d] = a; dvs[d] = b;
        @(posedge clk); #1;
        chk("busy_ready_low", ir[d], 0);
        if (!spam) iv[d] = 1'b0;
        while (!ov[d] && lat < 100) begin
            if (spam) begin dvd[d] = $urandom; dvs[d] = $urandom; end
            @(posedge clk); #1; lat++;
        end
        chk("latency", lat, 32 >> d);
        chk("quotient", q[d], eq);
        chk("remainder", r[d], er);
        chk("div_by_zero", dz[d], ez);
        for (int i = 0; i < bp; i++) begin
            if (spam) begin dvd[d] = $urandom; dvs[d] = $urandom; end
            @(posedge clk); #1;
            chk("bp_valid", ov[d], 1);
            chk("bp_quotient", q[d], eq);
            chk("bp_remainder", r[d], er);
            chk("bp_ready_low", ir[d], 0);
        end
        ordy[d] = 1'b1;
        @(posedge clk); #1;
        ordy[d] = 1'b0; iv[d] = 1'b0;
        chk("post_hs_valid", ov[d], 0);
        chk("post_hs_ready", ir[d], 1);
    endtask

    initial begin
        vt[0] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
        vt[1] = '{32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0};
        vt[2] = '{32'h5,          32'h9,          32'd0,          32'h5,          1'b0};
        vt[3] = '{32'hFFFFFFFF,   32'h80000000,   32'd1,          32'h7FFFFFFF,   1'b0};
        vt[4] = '{32'd0,          32'h1234,       32'd0,          32'd0,          1'b0};
        vt[5] = '{32'hDEADBEEF,   32'd0,          32'hFFFFFFFF,   32'hDEADBEEF,   1'b1};
        vt[6] = '{32'h12345678,   32'h1234,       32'h10004,      32'h0DA8,       1'b0};
        vt[7] = '{32'd50,         32'd8,          32'd6,          32'd2,          1'b0};
        iv = '0; ordy = '0;
        for (int d = 0; d < 4; d++) begin dvd[d] = '0; dvs[d] = '0; end

        cur = "reset";
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            chk("rst_valid", ov[d], 0);
            chk("rst_ready", ir[d], 0);
            chk("rst_quotient", q[d], 0);
            chk("rst_remainder", r[d], 0);
            chk("rst_dbz", dz[d], 0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < 4; d++) chk("ready_after_reset", ir[d], 1);

        for (int t = 0; t < 8; t++)
            for (int d = 0; d < 4; d++) begin
                cur = $sformatf("vec%0d dut%0d", t, d);
                run_op(d, vt[t].a, vt[t].b, 0, 1'b0, vt[t].eq, vt[t].er, vt[t].ez);
            end

        cur = "backpressure";
        run_op(0, 32'd100, 32'd7, 5, 1'b1, 32'd14, 32'd2, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("no_second_accept_ready", ir[0], 1);
        chk("no_second_accept_valid", ov[0], 0);

        cur = "reset_mid_op";
        iv[0] = 1'b1; dvd[0] = 32'd1000; dvs[0] = 32'd3;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_valid", ov[0], 0);
        chk("midrst_ready", ir[0], 0);
        chk("midrst_quotient", q[0], 0);
        begin
            int seen = 0;
            for (int i = 0; i < 40; i++) begin
                @(posedge clk); #1;
                if (ov[0]) seen = 1;
            end
            chk("midrst_no_valid", seen, 0);
        end
        run_op(0, 32'd50, 32'd8, 0, 1'b0, 32'd6, 32'd2, 1'b0);

        for (int d = 0; d < 4; d++)
            for (int i = 0; i < 150; i++) begin
                logic [31:0] a, b;
                a = $urandom;
                b = $urandom >> $urandom_range(0, 31);
                if (i % 25 == 0) b = '0;
                cur = $sformatf("rand dut%0d %0h/%0h", d, a, b);
                if (b == 0) run_op(d, a, b, i % 3, 1'b0, 32'hFFFFFFFF, a, 1'b1);
                else        run_op(d, a, b, i % 3, 1'b0, a / b, a % b, 1'b0);
            end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
